// File: rtl/spi_fifo_rx_if.sv
// rtl/spi_fifo_rx_if.sv - serial input and FIFO read-port bundle for spi_fifo_rx
interface spi_fifo_rx_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 4
);
  logic              sck;
  logic              cs_n;
  logic              mosi;
  logic              re;
  logic              clr_err;
  logic [DATA_W-1:0] dout;
  logic              valid;
  logic              empty;
  logic              full;
  logic [AW:0]       level;
  logic              ovf;
  logic              frame_err;

  modport master (
    output sck, cs_n, mosi, re, clr_err,
    input  dout, valid, empty, full, level, ovf, frame_err
  );

  modport slave (
    input  sck, cs_n, mosi, re, clr_err,
    output dout, valid, empty, full, level, ovf, frame_err
  );
endinterface

// File: rtl/spi_fifo_rx.sv
// rtl/spi_fifo_rx.sv - SPI mode-0 receiver deserializing MSB-first words into a read FIFO
module spi_fifo_rx #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic          clk,
  input  logic          nrst,
  spi_fifo_rx_if.slave  bus
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic              sck_m, sck_s, sck_d;
  logic              cs_m, cs_s;
  logic              mosi_m, mosi_s;
  logic              sck_rise;
  logic [0:0]        state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shift;
  logic              push;
  logic              ferr_set;
  logic              ovf_set;
  logic              do_rd;
  logic              do_wr;
  logic [AW:0]       level_next;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sck_m  <= 1'b0;
      sck_s  <= 1'b0;
      sck_d  <= 1'b0;
      cs_m   <= 1'b1;
      cs_s   <= 1'b1;
      mosi_m <= 1'b0;
      mosi_s <= 1'b0;
    end else begin
      sck_m  <= bus.sck;
      sck_s  <= sck_m;
      sck_d  <= sck_s;
      cs_m   <= bus.cs_n;
      cs_s   <= cs_m;
      mosi_m <= bus.mosi;
      mosi_s <= mosi_m;
    end
  end

  assign sck_rise = sck_s & ~sck_d;
  assign ferr_set = (state == S_SHIFT) && cs_s && (cnt != '0);

  // The completed word stays in shift for the push cycle: the next sck rise is at least 4 clk away.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_IDLE;
      cnt   <= '0;
      shift <= '0;
      push  <= 1'b0;
    end else begin
      push <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!cs_s) state <= S_SHIFT;
        end
        default: begin
          if (cs_s) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else if (sck_rise) begin
            shift <= {shift[DATA_W-2:0], mosi_s};
            if (cnt == LAST_BIT) begin
              cnt  <= '0;
              push <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // A read frees a slot in the same cycle, so a push into a full FIFO is still accepted.
  assign do_rd      = bus.re & ~bus.empty;
  assign do_wr      = push & (~bus.full | do_rd);
  assign ovf_set    = push & bus.full & ~do_rd;
  assign level_next = bus.level + (AW+1)'(do_wr) - (AW+1)'(do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      bus.level     <= '0;
      bus.empty     <= 1'b1;
      bus.full      <= 1'b0;
      bus.dout      <= '0;
      bus.valid     <= 1'b0;
      bus.ovf       <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr   <= rd_ptr + 1'b1;
        bus.dout <= mem[rd_ptr];
      end
      bus.valid     <= do_rd;
      bus.level     <= level_next;
      bus.empty     <= (level_next == '0);
      bus.full      <= (level_next == (AW+1)'(DEPTH));
      bus.ovf       <= ovf_set  | (bus.ovf & ~bus.clr_err);
      bus.frame_err <= ferr_set | (bus.frame_err & ~bus.clr_err);
    end
  end
endmodule

// File: tb/tb_spi_fifo_rx.sv
// tb/tb_spi_fifo_rx.sv - directed scoreboard bench for spi_fifo_rx
module tb_spi_fifo_rx;
  logic clk = 1'b0;
  logic nrst;

  always #5 clk = ~clk;

  spi_fifo_rx_if #(.DATA_W(32), .AW(4)) bus ();

  spi_fifo_rx #(.DATA_W(32), .DEPTH(16), .AW(4)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model[$];
  logic [31:0] last_dout = '0;
  bit          exp_ovf = 1'b0;
  bit          exp_ferr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_level"}, 32'(bus.level), 32'(model.size()));
    chk({tag, "_empty"}, 32'(bus.empty), 32'(model.size() == 0));
    chk({tag, "_full"},  32'(bus.full),  32'(model.size() == 16));
    chk({tag, "_ovf"},   32'(bus.ovf),   32'(exp_ovf));
    chk({tag, "_ferr"},  32'(bus.frame_err), 32'(exp_ferr));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_dout"},  bus.dout, 32'h0);
    chk({tag, "_valid"}, 32'(bus.valid), 32'h0);
    check_status(tag);
  endtask

  // Leaves sck high on the negedge where the final rising edge was driven.
  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      bus.mosi = w[31-i];
      bus.sck  = 1'b0;
      repeat (3) @(negedge clk);
      bus.sck = 1'b1;
      if (i != n - 1) repeat (3) @(negedge clk);
    end
  endtask

  task automatic send_word(input string tag, input logic [31:0] w, input bit rd_same);
    int pre;
    logic [31:0] e;
    pre = model.size();
    send_bits(w, 32);
    repeat (3) @(negedge clk);
    chk({tag, "_lvl_pre"}, 32'(bus.level), 32'(pre));
    if (rd_same) bus.re = 1'b1;
    @(negedge clk);
    bus.re = 1'b0;
    if (rd_same && pre > 0) begin
      e = model.pop_front();
      chk({tag, "_rd_valid"}, 32'(bus.valid), 32'h1);
      chk({tag, "_rd_dout"}, bus.dout, e);
      last_dout = e;
    end
    if (model.size() < 16) model.push_back(w);
    else exp_ovf = 1'b1;
    check_status(tag);
  endtask

  task automatic rd(input string tag);
    logic [31:0] e;
    bit has;
    has = (model.size() > 0);
    bus.re = 1'b1;
    @(negedge clk);
    bus.re = 1'b0;
    if (has) begin
      e = model.pop_front();
      chk({tag, "_valid"}, 32'(bus.valid), 32'h1);
      chk({tag, "_dout"}, bus.dout, e);
      last_dout = e;
    end else begin
      chk({tag, "_valid"}, 32'(bus.valid), 32'h0);
      chk({tag, "_dout_hold"}, bus.dout, last_dout);
    end
  endtask

  task automatic frame_begin();
    bus.sck  = 1'b0;
    bus.cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end();
    bus.cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_clr();
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    exp_ovf  = 1'b0;
    exp_ferr = 1'b0;
  endtask

  initial begin
    nrst = 1'b0;
    bus.sck = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    bus.re = 1'b0;
    bus.clr_err = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    frame_begin();
    send_word("t1_word", 32'hA5A5A5A5, 1'b0);
    frame_end();
    check_status("t1_frame");
    rd("t1_rd");
    check_status("t1_after");

    frame_begin();
    for (int i = 0; i < 3; i++) send_word("t2_word", 32'(i) * 32'h01010101, 1'b0);
    frame_end();
    for (int i = 0; i < 4; i++) rd("t2_rd");
    chk("t2_hold", bus.dout, 32'h02020202);
    check_status("t2_after");

    frame_begin();
    for (int i = 0; i < 17; i++) send_word("t3_word", 32'(i) * 32'h01010101, 1'b0);
    frame_end();
    chk("t3_full", 32'(bus.full), 32'h1);
    chk("t3_ovf", 32'(bus.ovf), 32'h1);
    for (int i = 0; i < 16; i++) rd("t3_rd");
    chk("t3_last", bus.dout, 32'h0F0F0F0F);
    pulse_clr();
    check_status("t3_clr");

    frame_begin();
    send_bits(32'hFFFFFFFF, 13);
    repeat (3) @(negedge clk);
    frame_end();
    exp_ferr = 1'b1;
    check_status("t4_partial");
    frame_begin();
    send_word("t4_word", 32'h12345678, 1'b0);
    frame_end();
    check_status("t4_frame");
    rd("t4_rd");
    pulse_clr();
    check_status("t4_clr");

    frame_begin();
    for (int i = 0; i < 16; i++) send_word("t5_fill", 32'h100 + 32'(i), 1'b0);
    send_word("t5_same", 32'hDEADBEEF, 1'b1);
    frame_end();
    for (int i = 0; i < 16; i++) rd("t5_rd");
    chk("t5_last", bus.dout, 32'hDEADBEEF);
    check_status("t5_after");

    frame_begin();
    send_word("t6_pre", 32'h55AA55AA, 1'b0);
    send_bits(32'h0F0F0F0F, 20);
    repeat (2) @(negedge clk);
    nrst = 1'b0;
    bus.cs_n = 1'b1;
    bus.sck = 1'b0;
    model.delete();
    last_dout = '0;
    exp_ovf = 1'b0;
    exp_ferr = 1'b0;
    @(negedge clk);
    check_reset("t6_reset");
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    frame_begin();
    send_word("t6_word", 32'hCAFEF00D, 1'b0);
    frame_end();
    check_status("t6_frame");
    rd("t6_rd");
    check_status("t6_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_fifo_rx.md
Name: spi_fifo_rx

Overview:
- Receive-side counterpart of the fifo_spi serializer: samples a single-wire SPI-style bit stream (sck, cs_n, mosi) from an external master and deserializes it MSB-first into DATA_W-bit words.
- Completed words are buffered in an internal FIFO that the local logic drains through a simple read-enable port.
- Sits at the FPGA boundary, on the MCU-to-FPGA path of the wifi link.

Parameters:
- DATA_W, 32, word width in bits; one frame = DATA_W bits.
- DEPTH, 16, FIFO depth in words; power of two.
- AW, 4, log2(DEPTH); pointer width.

Ports:
- clk  in  1  system clock.
- nrst  in  1  asynchronous active-low reset.
- sck  in  1  serial clock from master, asynchronous to clk.
- cs_n  in  1  frame select from master, active-low, asynchronous.
- mosi  in  1  serial data from master, asynchronous.
- re  in  1  read request, one word per cycle high.
- clr_err  in  1  clears ovf and frame_err (synchronous, one-cycle pulse).
- dout  out  DATA_W  read data, registered.
- valid  out  1  one-cycle pulse, dout holds a newly read word.
- empty  out  1  FIFO holds no words.
- full  out  1  FIFO holds DEPTH words.
- level  out  AW+1  number of stored words, 0..DEPTH.
- ovf  out  1  sticky; a completed word was dropped because the FIFO was full.
- frame_err  out  1  sticky; cs_n deasserted mid-word.

Behaviour:
- Reset (nrst low, async): dout=0, valid=0, empty=1, full=0, level=0, ovf=0, frame_err=0, pointers=0, bit counter=0, shift register=0, synchronizers=reset level (sck 0, cs_n 1, mosi 0).
- Sync: sck, cs_n and mosi each pass through a 2-FF synchronizer, so all three keep the same latency. An sck rising edge is detected as sync_sck=1 with the previous value 0.
- Timing requirement on the master: sck high ≥2 clk, sck low ≥2 clk, mosi stable ≥2 clk around sck rising. Mode 0 (sample on rising edge), MSB first.
- Receive FSM, two states:
  - IDLE: sync cs_n=1; bit counter held at 0. Go to SHIFT on sync cs_n=0.
  - SHIFT: on each sck rising edge, shift = {shift[DATA_W-2:0], mosi}, cnt+1.
  - When cnt reaches DATA_W-1 and a rising edge occurs, assert push for exactly one cycle with word = {shift[DATA_W-2:0], mosi}, set cnt=0, and stay in SHIFT. Back-to-back words within one cs_n frame are allowed.
  - On sync cs_n=1 in SHIFT: if cnt≠0, set frame_err and discard the partial word. In all cases clear cnt and go to IDLE.
  - An sck edge in the same cycle that cs_n deasserts is ignored.
- Push latency: the word is visible in the FIFO (empty falls, level increments) 1 clk after the push pulse. That is 4 clk after the last synchronized sck rising edge at the pins (2 sync + 1 edge/shift + 1 write).
- FIFO and read port:
  - Pointers are AW bits and wrap modulo DEPTH. level is tracked as a counter.
  - re while empty=0: dout=mem[rd_ptr] on the next clk edge, valid=1 for that one cycle, rd_ptr+1.
  - re while empty=1 is ignored: no valid, dout holds, no error.
  - dout holds its last value until the next valid read.
- Boundary conditions:
  - push and re in the same cycle, FIFO non-empty and not full: both happen, level unchanged.
  - push and re in the same cycle while full: read happens, push accepted, level stays DEPTH, no ovf.
  - push and re in the same cycle while empty: push only, re ignored.
  - push while full without re: word dropped, ovf=1, pointers and level unchanged.
  - full = (level==DEPTH); empty = (level==0). Both are registered, consistent with level every cycle.
  - clr_err clears ovf and frame_err. If clr_err coincides with a new set event, the set wins.
- Reset mid-frame: everything returns to reset values immediately and the partial word is lost. After nrst rises, receiving resumes at the next cs_n falling edge. If cs_n is already low at release, the FSM enters SHIFT from bit 0, so the master must re-frame.

Test Plan:
- Reset, then one frame with cs_n low sending 0xA5A5A5A5 MSB-first at sck = clk/6, then re pulse -> empty falls 4 clk after the last sck rise; level=1; next cycle valid=1, dout=0xA5A5A5A5; empty=1, level=0.
- One cs_n frame with 3 back-to-back words 0x00000000, 0x01010101, 0x02020202 (fifo_spi counting pattern), then re held 4 cycles -> valid on 3 consecutive cycles with dout in that order; 4th re ignored, dout stays 0x02020202.
- 17 words 0x00000000..0x10101010 with no reads -> full=1 and level=16 after the 16th; 17th word dropped, ovf=1. Drain 16 reads -> last dout=0x0F0F0F0F. clr_err -> ovf=0.
- cs_n raised after 13 bits, then a full frame 0x12345678 -> frame_err=1, level=1, read returns 0x12345678 (no partial-bit contamination).
- FIFO full, re asserted in the exact cycle of push of 0xDEADBEEF -> level stays 16, ovf=0; after draining, the last word read is 0xDEADBEEF.
- nrst pulsed low after 20 bits of a frame -> all outputs at reset values. After release, a new frame 0xCAFEF00D is read back correctly; frame_err=0.
